io_fcs32_chk: RTL
=================

# io_fcs32_chk

Receive-side FCS checker for the byte-serial IO link. It accepts a framed byte stream whose last four bytes are a CRC-32 FCS in the format produced by the link's transmit-side FCS generator. It strips the FCS, forwards the payload with a fixed 4-byte hold-back, and reports per-frame good/bad status plus saturating statistics. It sits between the link deserializer and the IO frame parser.

## Interface
Parameters:
- MIN_LEN, 5: minimum total frame length in bytes, FCS included. Must be ≥5. Shorter frames are runts.

Ports:
- clk_sys  in  1  system clock
- rst_sys_n  in  1  reset, asynchronous, active-low
- rx_din  in  8  received byte
- rx_din_vld  in  1  rx_din valid this cycle
- rx_sop  in  1  first byte of frame; qualified by rx_din_vld
- rx_eop  in  1  last byte of frame (last FCS byte); qualified by rx_din_vld
- cnt_clr  in  1  synchronous clear of good_cnt/bad_cnt
- pl_dout  out  8  payload byte
- pl_vld  out  1  pl_dout valid
- pl_sop  out  1  first payload byte
- pl_eop  out  1  last payload byte
- frame_done  out  1  one-cycle pulse: frame status valid
- frame_ok  out  1  FCS correct and length ≥ MIN_LEN; held until next frame_done
- frame_err  out  1  inverse condition of frame_ok; held until next frame_done
- frame_abort  out  1  frame ended by new rx_sop, not rx_eop; held until next frame_done
- frame_len  out  16  payload byte count (total − 4, floor 0), saturating at 0xFFFF; held
- good_cnt  out  16  good frames, saturating
- bad_cnt  out  16  bad, runt and aborted frames, saturating

## Operation
- CRC: IEEE 802.3 CRC-32, polynomial 0x04C11DB7, initial value all-ones. Byte-wise update, each byte bit 0 first (reflected). The FCS is the complemented reflected CRC, sent least-significant byte first. The check is a residue check over all bytes including the FCS. The reflected register must equal 0xDEBB20E3 after the last byte; in MSB-first register form this is 0xC704DD7B.
- Accepted byte: rx_din_vld=1, and either rx_sop=1 or the FSM is not in IDLE. In IDLE, valid bytes without rx_sop are discarded with no effect.
- FSM states:
  - IDLE: wait for an accepted rx_sop byte.
  - FILL: fewer than 4 bytes held.
  - PASS: 4 bytes held.
- Transitions:
  - sop byte: CRC reset to all-ones and then updated with that byte; held count = 1; go to FILL.
  - FILL: each accepted byte is pushed. The 4th byte moves the FSM to PASS. No payload output.
  - PASS: each accepted byte emits the oldest held byte on pl_dout and pushes the new byte.
  - Either state: an rx_eop byte → status, then IDLE.
- pl_sop marks the first emitted byte of the frame. pl_eop coincides with the emission caused by the eop byte. Held bytes at eop are the FCS and are discarded.
- Runt: total bytes < MIN_LEN → frame_err, regardless of CRC.
- rx_sop in FILL/PASS (no eop seen): close the current frame with frame_err=1 and frame_abort=1. Held bytes are discarded, and no pl_eop is emitted for it. The sop byte starts a new frame in the same cycle.
- rx_sop and rx_eop on the same byte: 1-byte frame → runt, frame_err.
- rx_din_vld=0: all state held; gaps are allowed anywhere in a frame.
- Counters:
  - frame_ok increments good_cnt; any frame_err increments bad_cnt.
  - Both saturate at 0xFFFF.
  - cnt_clr zeroes both. If cnt_clr and an increment occur in the same cycle, the counter becomes 1.

## Timing
- All outputs are registered. pl_* appears 1 cycle after the accepting input cycle.
- frame_done, frame_ok, frame_err, frame_abort and frame_len update 1 cycle after the eop (or aborting sop) input cycle, aligned with pl_eop.
- Counters update on the same edge as frame_done.
- Reset values:
  - All outputs 0; frame_len 0.
  - FSM IDLE, CRC all-ones, held count 0.
- Throughput: one byte per cycle sustained, no back-pressure.
- Reset mid-frame: the frame is dropped silently, with no frame_done.

## Test plan
- Good frame: send 0x31..0x39 ("123456789"), then 0x26 0x39 0xF4 0xCB with eop on the last byte. Required: 9 payload bytes 0x31..0x39, pl_sop on 0x31, pl_eop on 0x39; frame_ok=1, frame_len=9, good_cnt=1.
- Corrupt frame: same stimulus with the last byte 0xCA. Required: the same payload is still emitted; frame_err=1, frame_abort=0, bad_cnt=1.
- Runt: send 4 bytes with eop on the 4th, then a 1-byte sop+eop frame. Required: no pl_vld; two frame_done pulses, each with frame_err=1; bad_cnt=2.
- Abort: send 6 bytes of frame A with no eop, then the good frame from the first scenario starting with sop. Required:
  - frame A: 2 payload bytes emitted, no pl_eop, then frame_done with frame_abort=1;
  - good frame: passes with frame_ok=1.
- Gaps and idle garbage: good frame with rx_din_vld toggled randomly, plus valid non-sop bytes sent while in IDLE. Required: identical payload and status as the gap-free case.
- Saturation and clear:
  - Force 65 536 good frames (or preload): good_cnt holds at 0xFFFF.
  - Assert cnt_clr together with a good frame_done: good_cnt becomes 1.
  - Assert rst_sys_n low mid-frame: all outputs read 0.

Source files
------------

// File: rtl/io_fcs32_chk.sv
// Receive-side CRC-32 FCS checker: strips the trailing 4-byte FCS,
// forwards the payload with a 4-byte hold-back and reports frame status.
module io_fcs32_chk #(
    parameter int MIN_LEN = 5
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic [7:0]  rx_din,
    input  logic        rx_din_vld,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic        cnt_clr,
    output logic [7:0]  pl_dout,
    output logic        pl_vld,
    output logic        pl_sop,
    output logic        pl_eop,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        frame_abort,
    output logic [15:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, PASS} state_t;

    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [16:0] MIN_L   = 17'(MIN_LEN);
    localparam logic [16:0] TOT_MAX = '1;

    function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                            input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Payload length = total - 4, floored at 0, clamped to 16 bits.
    function automatic logic [15:0] pl_len(input logic [16:0] t);
        logic [16:0] p;
        p = t - 17'd4;
        if (t < 17'd4) return 16'd0;
        return p[16] ? 16'hFFFF : p[15:0];
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] hold_q, hold_d;
    logic [16:0] tot_q, tot_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d, psop_q, psop_d, peop_q, peop_d;
    logic        done_q, done_d, ok_q, ok_d, err_q, err_d;
    logic        abt_q, abt_d;
    logic [15:0] len_q, len_d;
    logic [15:0] good_q, good_d, bad_q, bad_d;

    logic        acc, emit, abort, close, ok_now, good_inc;
    logic [1:0]  bad_inc;
    logic [31:0] crc_next;
    logic [16:0] tot_inc, bad_sum;

    assign acc      = rx_din_vld & (rx_sop | (state_q != IDLE));
    assign emit     = acc & ~rx_sop & (state_q == PASS);
    assign abort    = acc & rx_sop & (state_q != IDLE);
    assign close    = acc & rx_eop;
    assign crc_next = crc_upd(rx_sop ? 32'hFFFFFFFF : crc_q, rx_din);
    assign tot_inc  = rx_sop ? 17'd1
                    : (tot_q == TOT_MAX ? tot_q : tot_q + 17'd1);
    assign ok_now   = (crc_next == RESIDUE) && (tot_inc >= MIN_L);
    assign good_inc = close & ~abort & ok_now;
    assign bad_inc  = {1'b0, abort} + {1'b0, close & ~ok_now};
    assign bad_sum  = {1'b0, bad_q} + {15'd0, bad_inc};

    // FSM state register
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // FSM next state: sop restarts, eop ends, 4th byte fills the hold-back
    always_comb begin
        state_d = state_q;
        if (acc) begin
            if (rx_sop) begin
                state_d = rx_eop ? IDLE : FILL;
            end else if (rx_eop) begin
                state_d = IDLE;
            end else if (state_q == FILL && tot_q == 17'd3) begin
                state_d = PASS;
            end
        end
    end

    // FSM outputs: datapath, status and counter next values
    always_comb begin
        crc_d  = crc_q;
        hold_d = hold_q;
        tot_d  = tot_q;
        dout_d = emit ? hold_q[31:24] : dout_q;
        vld_d  = emit;
        psop_d = emit & (tot_q == 17'd4);
        peop_d = emit & rx_eop;
        done_d = abort | close;
        ok_d   = ok_q;
        err_d  = err_q;
        abt_d  = abt_q;
        len_d  = len_q;
        if (acc) begin
            crc_d  = crc_next;
            hold_d = {hold_q[23:0], rx_din};
            tot_d  = tot_inc;
        end
        if (close) begin
            crc_d = 32'hFFFFFFFF;
            tot_d = 17'd0;
        end
        if (abort) begin
            ok_d  = 1'b0;
            err_d = 1'b1;
            abt_d = 1'b1;
            len_d = pl_len(tot_q);
        end else if (close) begin
            ok_d  = ok_now;
            err_d = ~ok_now;
            abt_d = 1'b0;
            len_d = pl_len(tot_inc);
        end
        if (cnt_clr) begin
            good_d = {15'd0, good_inc};
            bad_d  = {14'd0, bad_inc};
        end else begin
            good_d = (good_inc && good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
            bad_d  = bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            crc_q  <= 32'hFFFFFFFF;
            hold_q <= 32'd0;
            tot_q  <= 17'd0;
            dout_q <= 8'd0;
            vld_q  <= 1'b0;
            psop_q <= 1'b0;
            peop_q <= 1'b0;
            done_q <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
            abt_q  <= 1'b0;
            len_q  <= 16'd0;
            good_q <= 16'd0;
            bad_q  <= 16'd0;
        end else begin
            crc_q  <= crc_d;
            hold_q <= hold_d;
            tot_q  <= tot_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            psop_q <= psop_d;
            peop_q <= peop_d;
            done_q <= done_d;
            ok_q   <= ok_d;
            err_q  <= err_d;
            abt_q  <= abt_d;
            len_q  <= len_d;
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign pl_dout     = dout_q;
    assign pl_vld      = vld_q;
    assign pl_sop      = psop_q;
    assign pl_eop      = peop_q;
    assign frame_done  = done_q;
    assign frame_ok    = ok_q;
    assign frame_err   = err_q;
    assign frame_abort = abt_q;
    assign frame_len   = len_q;
    assign good_cnt    = good_q;
    assign bad_cnt     = bad_q;

endmodule
